// File: rtl/dds_quarter_wave_ctrl_pkg.sv
// Shared constants for the quarter-wave DDS: phase field positions, pipeline depth, quadrants.
package dds_pkg;

    localparam int DDS_LAT = 3;

    typedef enum logic [1:0] {
        Q0 = 2'b00,
        Q1 = 2'b01,
        Q2 = 2'b10,
        Q3 = 2'b11
    } quad_e;

    function automatic int sgn_bit(input int pw);
        return pw - 1;
    endfunction

    function automatic int mir_bit(input int pw);
        return pw - 2;
    endfunction

    // LSB of the ROM index field; everything below it is truncated
    function automatic int k_lsb(input int pw, input int aw);
        return pw - 2 - aw;
    endfunction

endpackage

// File: rtl/dds_quarter_wave_ctrl_phase_acc.sv
// Step register, phase accumulator with clear-over-enable priority, and phase offset adder.
module dds_phase_acc
    import dds_pkg::*;
#(
    parameter int PHASE_WIDTH = 32,
    parameter int ADDR_WIDTH  = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic                   phase_clr,
    input  logic                   fcw_load,
    input  logic [PHASE_WIDTH-1:0] fcw_in,
    input  logic [PHASE_WIDTH-1:0] pcw_in,
    output logic                   launch,
    output logic [ADDR_WIDTH+1:0]  ph_hi
);

    localparam int KL = k_lsb(PHASE_WIDTH, ADDR_WIDTH);

    logic [PHASE_WIDTH-1:0] fcw_r;
    logic [PHASE_WIDTH-1:0] acc;

    assign launch = en | phase_clr;

    // A clear launches its sample from phase zero, so the offset sees 0 rather than acc
    assign ph_hi = (ADDR_WIDTH+2)'(((phase_clr ? '0 : acc) + pcw_in) >> KL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fcw_r <= '0;
            acc   <= '0;
        end else begin
            if (fcw_load)
                fcw_r <= fcw_in;
            if (phase_clr)
                acc <= '0;
            else if (en)
                acc <= acc + fcw_r;
        end
    end

endmodule

// File: rtl/dds_quarter_wave_ctrl.sv
// DDS quarter-wave controller: mirrors the ROM address per quadrant and restores sign on the data.
module dds_quarter_wave_ctrl
    import dds_pkg::*;
#(
    parameter int PHASE_WIDTH = 32,
    parameter int ADDR_WIDTH  = 8,
    parameter int DATA_WIDTH  = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic [PHASE_WIDTH-1:0] fcw_in,
    input  logic                   fcw_load,
    input  logic [PHASE_WIDTH-1:0] pcw_in,
    input  logic                   phase_clr,
    output logic [ADDR_WIDTH-1:0]  rom_addr,
    input  logic [DATA_WIDTH-1:0]  rom_q,
    output logic [DATA_WIDTH:0]    dout,
    output logic                   dout_valid
);

    logic                  launch;
    logic [ADDR_WIDTH+1:0] ph_hi;
    quad_e                 quad;
    logic [ADDR_WIDTH-1:0] k;
    logic [DATA_WIDTH:0]   mag;
    logic [DDS_LAT-1:1]    vld_pipe;
    logic [DDS_LAT-1:1]    sgn_pipe;

    dds_phase_acc #(
        .PHASE_WIDTH(PHASE_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_acc (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .phase_clr(phase_clr),
        .fcw_load (fcw_load),
        .fcw_in   (fcw_in),
        .pcw_in   (pcw_in),
        .launch   (launch),
        .ph_hi    (ph_hi)
    );

    assign quad = quad_e'(ph_hi[ADDR_WIDTH+1:ADDR_WIDTH]);
    assign k    = ph_hi[ADDR_WIDTH-1:0];
    assign mag  = {1'b0, rom_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rom_addr   <= '0;
            vld_pipe   <= '0;
            sgn_pipe   <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
        end else begin
            vld_pipe <= {vld_pipe[DDS_LAT-2:1], launch};
            sgn_pipe <= {sgn_pipe[DDS_LAT-2:1], (quad == Q2) || (quad == Q3)};
            // Address only moves on a launch so idle cycles leave the ROM port quiet
            if (launch)
                rom_addr <= ((quad == Q1) || (quad == Q3)) ? ~k : k;
            dout_valid <= vld_pipe[DDS_LAT-1];
            if (vld_pipe[DDS_LAT-1])
                dout <= sgn_pipe[DDS_LAT-1] ? -mag : mag;
        end
    end

endmodule

// File: tb/tb_dds_quarter_wave_ctrl.sv
// Self-checking bench for dds_quarter_wave_ctrl with a contract-table ROM and a behavioural model.
module tb_dds_quarter_wave_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        fcw_load = 1'b0;
    logic        phase_clr = 1'b0;
    logic [31:0] fcw_in = '0;
    logic [31:0] pcw_in = '0;
    logic [7:0]  rom_addr;
    logic [7:0]  rom_q = '0;
    logic [8:0]  dout;
    logic        dout_valid;

    int rom [256];
    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] m_acc, m_fcw;
    int          exp_addr, exp_dout;
    bit          exp_vld;
    int          pv[$];
    int          pd[$];

    dds_quarter_wave_ctrl #(
        .PHASE_WIDTH(32),
        .ADDR_WIDTH (8),
        .DATA_WIDTH (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .fcw_in    (fcw_in),
        .fcw_load  (fcw_load),
        .pcw_in    (pcw_in),
        .phase_clr (phase_clr),
        .rom_addr  (rom_addr),
        .rom_q     (rom_q),
        .dout      (dout),
        .dout_valid(dout_valid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rom_q <= 8'(rom[rom_addr]);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [8:0] s9(input int v);
        logic [31:0] t;
        t = v;
        return t[8:0];
    endfunction

    task automatic model_reset();
        m_acc = '0; m_fcw = '0;
        exp_addr = 0; exp_dout = 0; exp_vld = 0;
        pv = {0, 0}; pd = {0, 0};
    endtask

    task automatic check_all();
        chk("rom_addr", 32'(rom_addr), 32'(exp_addr));
        chk("dout_valid", 32'(dout_valid), 32'(exp_vld));
        chk("dout", 32'(dout), 32'(s9(exp_dout)));
    endtask

    // One clock: drive, predict from phase arithmetic, then check at the falling edge
    task automatic step(input bit e, input bit ld, input bit cl,
                        input logic [31:0] f, input logic [31:0] p);
        logic [31:0] ph;
        int quad, idx, addr, val;
        bit launch;
        en = e; fcw_load = ld; phase_clr = cl; fcw_in = f; pcw_in = p;
        launch = e | cl;
        ph   = (cl ? 32'd0 : m_acc) + p;
        quad = int'(ph / 32'h4000_0000);
        idx  = int'((ph % 32'h4000_0000) / 32'h0040_0000);
        addr = (quad % 2 == 1) ? 255 - idx : idx;
        val  = (quad >= 2) ? -rom[addr] : rom[addr];
        @(posedge clk);
        m_acc = cl ? 32'd0 : (e ? m_acc + m_fcw : m_acc);
        if (ld) m_fcw = f;
        if (launch) exp_addr = addr;
        pv.push_back(int'(launch)); pd.push_back(val);
        exp_vld = (pv[0] != 0);
        if (exp_vld) exp_dout = pd[0];
        void'(pv.pop_front()); void'(pd.pop_front());
        @(negedge clk);
        check_all();
    endtask

    initial begin
        for (int k = 0; k < 256; k++)
            rom[k] = $rtoi(255.0 * $sin((k + 0.5) * 3.14159265358979 / 512.0) + 0.5);
        model_reset();

        // Reset with random inputs
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            en = 1'($urandom); fcw_load = 1'($urandom); phase_clr = 1'($urandom);
            fcw_in = $urandom; pcw_in = $urandom;
            #1;
            chk("rst_addr", 32'(rom_addr), 32'd0);
            chk("rst_valid", 32'(dout_valid), 32'd0);
            chk("rst_dout", 32'(dout), 32'd0);
        end
        @(negedge clk);
        en = 0; fcw_load = 0; phase_clr = 0;
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 4; i++) step(0, 0, 0, 32'h0, $urandom);

        // Full sweep
        step(0, 1, 0, 32'h0040_0000, 32'h0);
        for (int i = 0; i < 1024; i++) begin
            step(1, 0, 0, 32'h0, 32'h0);
            chk("sweep_addr", 32'(rom_addr),
                32'(((i / 256) % 2 == 1) ? 255 - (i % 256) : (i % 256)));
            if (i == 1) chk("sweep_valid_early", 32'(dout_valid), 32'd0);
            if (i == 2) begin
                chk("sweep_valid_first", 32'(dout_valid), 32'd1);
                chk("sweep_first", 32'(dout), 32'(s9(rom[0])));
            end
        end
        for (int i = 0; i < 3; i++) step(0, 0, 0, 32'h0, 32'h0);

        // Quadrant boundaries
        step(0, 1, 1, 32'h0, 32'h0);
        step(1, 0, 0, 32'h0, 32'h3FC0_0000); chk("q_addr0", 32'(rom_addr), 32'd255);
        step(1, 0, 0, 32'h0, 32'h4000_0000); chk("q_addr1", 32'(rom_addr), 32'd255);
        step(1, 0, 0, 32'h0, 32'h8000_0000); chk("q_addr2", 32'(rom_addr), 32'd0);
        chk("q_dout0", 32'(dout), 32'(s9(rom[255])));
        step(0, 0, 0, 32'h0, 32'h0); chk("q_dout1", 32'(dout), 32'(s9(rom[255])));
        step(0, 0, 0, 32'h0, 32'h0); chk("q_dout2", 32'(dout), 32'(s9(-rom[0])));
        step(0, 0, 0, 32'h0, 32'h0);

        // Clear priority and wrap
        step(0, 1, 0, 32'h1234_5678, 32'h0);
        for (int i = 0; i < 5; i++) step(1, 0, 0, 32'h0, 32'h0);
        step(1, 0, 1, 32'h0, 32'h0123_4567);
        step(1, 0, 0, 32'h0, 32'h0);
        step(0, 1, 1, 32'hFFC0_0000, 32'h0);
        step(1, 1, 0, 32'h0040_0000, 32'h0);
        step(1, 0, 0, 32'h0, 32'h0);
        step(1, 0, 0, 32'h0, 32'h0); chk("wrap_addr", 32'(rom_addr), 32'd0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 32'h0, 32'h0);

        // Step change mid-run
        step(0, 1, 1, 32'h0040_0000, 32'h0);
        for (int i = 0; i < 4; i++) step(1, 0, 0, 32'h0, 32'h0);
        step(1, 1, 0, 32'h0080_0000, 32'h0);
        for (int i = 0; i < 6; i++) step(1, 0, 0, 32'h0, 32'h0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 32'h0, 32'h0);

        // Mid-run asynchronous reset
        step(0, 1, 1, 32'h0040_0000, 32'h0);
        for (int i = 0; i < 100; i++) step(1, 0, 0, 32'h0, 32'h0);
        #1 rst_n = 1'b0;
        #1;
        chk("mrst_valid", 32'(dout_valid), 32'd0);
        chk("mrst_dout", 32'(dout), 32'd0);
        chk("mrst_addr", 32'(rom_addr), 32'd0);
        #1 en = 0; fcw_load = 0; phase_clr = 0;
        rst_n = 1'b1;
        model_reset();
        step(1, 1, 0, 32'h0040_0000, 32'h0); chk("mrst_restart", 32'(rom_addr), 32'd0);
        step(1, 0, 0, 32'h0, 32'h0);
        step(1, 0, 0, 32'h0, 32'h0); chk("mrst_resume", 32'(dout_valid), 32'd1);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 32'h0, 32'h0);

        // Randomized traffic
        for (int i = 0; i < 300; i++)
            step(($urandom % 4) != 0, ($urandom % 8) == 0, ($urandom % 16) == 0,
                 $urandom, ($urandom % 2 == 0) ? 32'h0 : $urandom);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 32'h0, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
